crc4_tx: RTL and testbench

- Serial CRC-4 frame transmitter. It is the sending end of the serial signature path whose receiver is the 4-bit SISR (polynomial g(x) = x^4 + x + 1).
- It accepts a DATA_W-bit word, shifts it out MSB-first on a 1-bit line, then appends the 4-bit remainder R = M(x)·x^4 mod g(x), also MSB-first.
- A receiving SISR that starts from 0 and is fed the whole frame (data followed by CRC) ends in state 4'b0000.

---
 rtl/crc4_pkg.sv | 20 ++
 rtl/crc4_tx_if.sv | 23 ++
 rtl/crc4_lfsr.sv | 24 ++
 rtl/crc4_tx.sv | 117 +++++++++++
 tb/tb_crc4_tx.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc4_pkg.sv
// Shared CRC-4 definitions for the serial signature path, g(x) = x^4 + x + 1.
// crc4_step is the single-bit Galois update used by both transmitter and receiver.
package crc4_pkg;

    localparam int CRC_W = 4;
    localparam logic [CRC_W-1:0] POLY = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

    function automatic logic [CRC_W-1:0] crc4_step(input logic [CRC_W-1:0] r, input logic d);
        logic fb;
        fb = d ^ r[CRC_W-1];
        return {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

endpackage

// File: rtl/crc4_tx_if.sv
// Frame request and serial output bundle of the CRC-4 transmitter.
interface crc4_tx_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              so;
    logic              so_vld;
    logic              sof;
    logic              eof;
    logic [3:0]        crc;

    modport master (
        output start, data,
        input  busy, so, so_vld, sof, eof, crc
    );

    modport slave (
        input  start, data,
        output busy, so, so_vld, sof, eof, crc
    );
endinterface

// File: rtl/crc4_lfsr.sv
// Premultiplied 4-bit Galois CRC register; in shift mode it drains the remainder MSB-first.
module crc4_lfsr
    import crc4_pkg::*;
(
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clr,
    input  logic             en,
    input  logic             shift,
    input  logic             d,
    output logic [CRC_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= shift ? {q[CRC_W-2:0], 1'b0} : crc4_step(q, d);
        end
    end

endmodule

// File: rtl/crc4_tx.sv
// Serial CRC-4 frame transmitter: DATA_W payload bits MSB-first followed by the 4-bit remainder.
//   state | meaning
//   IDLE  | waiting for start; loads payload, clears remainder and counter
//   DATA  | shifting payload out while folding each bit into the remainder
//   CRC   | shifting the 4 remainder bits out, eof on the last one
module crc4_tx
    import crc4_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       rst_b,
    crc4_tx_if.slave   bus
);

    // The same counter also paces the 4 CRC cycles, so it needs at least 2 bits.
    localparam int CNT_W = ($clog2(DATA_W + 1) > 2) ? $clog2(DATA_W + 1) : 2;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  cnt;
    logic [CRC_W-1:0]  r;
    logic              data_last;
    logic              crc_last;
    logic              lfsr_clr;
    logic              lfsr_en;
    logic              lfsr_shift;

    assign data_last = (cnt == CNT_W'(DATA_W - 1));
    assign crc_last  = (cnt == CNT_W'(CRC_W - 1));
    assign bus.crc   = r;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = DATA;
            DATA:    if (data_last) state_nxt = CRC;
            CRC:     if (crc_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = 1'b0;
        bus.so     = 1'b0;
        bus.so_vld = 1'b0;
        bus.sof    = 1'b0;
        bus.eof    = 1'b0;
        lfsr_clr   = 1'b0;
        lfsr_en    = 1'b0;
        lfsr_shift = 1'b0;
        case (state)
            IDLE: begin
                lfsr_clr = bus.start;
            end
            DATA: begin
                bus.busy   = 1'b1;
                bus.so     = shift[DATA_W-1];
                bus.so_vld = 1'b1;
                bus.sof    = (cnt == '0);
                lfsr_en    = 1'b1;
            end
            CRC: begin
                bus.busy   = 1'b1;
                bus.so     = r[CRC_W-1];
                bus.so_vld = 1'b1;
                bus.eof    = crc_last;
                lfsr_en    = 1'b1;
                lfsr_shift = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            shift <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift <= bus.data;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    shift <= shift << 1;
                    cnt   <= data_last ? '0 : cnt + CNT_W'(1);
                end
                CRC: begin
                    cnt   <= crc_last ? '0 : cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    crc4_lfsr u_lfsr (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (lfsr_clr),
        .en    (lfsr_en),
        .shift (lfsr_shift),
        .d     (shift[DATA_W-1]),
        .q     (r)
    );

endmodule

// File: tb/tb_crc4_tx.sv
// Scoreboard bench for crc4_tx at DATA_W=8 and DATA_W=1 with a receiver-side SISR loopback.
module tb_crc4_tx;
    import crc4_pkg::*;

    typedef struct {
        logic       so;
        logic       sof;
        logic       eof;
        logic       crc_chk;
        logic [3:0] crc_exp;
    } exp_t;

    logic clk;
    logic rst_b;
    int   n_cmp;
    int   n_bad;

    exp_t q8[$];
    exp_t q1[$];

    crc4_tx_if #(.DATA_W(8)) b8 ();
    crc4_tx_if #(.DATA_W(1)) b1 ();

    crc4_tx #(.DATA_W(8)) dut8 (.clk(clk), .rst_b(rst_b), .bus(b8));
    crc4_tx #(.DATA_W(1)) dut1 (.clk(clk), .rst_b(rst_b), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Independent long-division reference: M(x)*x^4 mod (x^4+x+1).
    function automatic logic [3:0] rem_ld(input logic [7:0] m, input int w);
        logic [4:0] r;
        r = '0;
        for (int i = w - 1; i >= 0; i--) begin
            r = {r[3:0], m[i]};
            if (r[4]) r = r ^ 5'b10011;
        end
        for (int i = 0; i < 4; i++) begin
            r = {r[3:0], 1'b0};
            if (r[4]) r = r ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    task automatic push8(input logic [7:0] d, input logic [3:0] c);
        exp_t e;
        for (int i = 7; i >= 0; i--) begin
            e.so = d[i]; e.sof = (i == 7); e.eof = 1'b0; e.crc_chk = 1'b0; e.crc_exp = c;
            q8.push_back(e);
        end
        for (int j = 3; j >= 0; j--) begin
            e.so = c[j]; e.sof = 1'b0; e.eof = (j == 0); e.crc_chk = (j == 3); e.crc_exp = c;
            q8.push_back(e);
        end
    endtask

    task automatic push1(input logic d, input logic [3:0] c);
        exp_t e;
        e.so = d; e.sof = 1'b1; e.eof = 1'b0; e.crc_chk = 1'b0; e.crc_exp = c;
        q1.push_back(e);
        for (int j = 3; j >= 0; j--) begin
            e.so = c[j]; e.sof = 1'b0; e.eof = (j == 0); e.crc_chk = (j == 3); e.crc_exp = c;
            q1.push_back(e);
        end
    endtask

    task automatic wait_idle8();
        int n;
        n = 0;
        while (b8.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle8_timeout", b8.busy, 0);
    endtask

    task automatic send8(input logic [7:0] d, input logic [3:0] c);
        @(negedge clk);
        b8.start = 1'b1;
        b8.data  = d;
        push8(d, c);
        @(negedge clk);
        b8.start = 1'b0;
        b8.data  = 8'($urandom);
        wait_idle8();
    endtask

    task automatic send1(input logic d, input logic [3:0] c);
        int n;
        @(negedge clk);
        b1.start = 1'b1;
        b1.data  = d;
        push1(d, c);
        @(negedge clk);
        b1.start = 1'b0;
        b1.data  = ~d;
        n = 0;
        while (b1.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle1_timeout", b1.busy, 0);
    endtask

    // Monitor for the 8-bit transmitter, including SISR loopback of each whole frame.
    logic bits8[0:11];
    int   nb8;
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] sig;
        int k;
        if (rst_b) begin
            if (b8.so_vld) begin
                chk("busy8_in_frame", b8.busy, 1);
                if (q8.size() == 0) begin
                    chk("unexpected_bit8", 1, 0);
                end else begin
                    e = q8.pop_front();
                    chk("so8", b8.so, e.so);
                    chk("sof8", b8.sof, e.sof);
                    chk("eof8", b8.eof, e.eof);
                    if (e.crc_chk) chk("crc8", b8.crc, e.crc_exp);
                end
                if (b8.sof) nb8 = 0;
                if (nb8 < 12) bits8[nb8] = b8.so;
                nb8++;
                if (b8.eof) begin
                    chk("frame8_len", nb8, 12);
                    if (nb8 == 12) begin
                        sig = '0;
                        for (int i = 0; i < 12; i++) sig = crc4_step(sig, bits8[i]);
                        chk("loop_sig", sig, 0);
                        k = $urandom_range(0, 11);
                        sig = '0;
                        for (int i = 0; i < 12; i++) sig = crc4_step(sig, bits8[i] ^ (i == k));
                        chk("flip_sig_nonzero", (sig != 4'h0), 1);
                    end
                end
            end else begin
                chk("idle8_outs", {b8.busy, b8.so, b8.sof, b8.eof}, 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_b) begin
            if (b1.so_vld) begin
                if (q1.size() == 0) begin
                    chk("unexpected_bit1", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("so1", b1.so, e.so);
                    chk("sof1", b1.sof, e.sof);
                    chk("eof1", b1.eof, e.eof);
                    if (e.crc_chk) chk("crc1", b1.crc, e.crc_exp);
                end
            end else begin
                chk("idle1_outs", {b1.busy, b1.so, b1.sof, b1.eof}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_cmp = 0;
        n_bad = 0;
        nb8   = 0;
        b1.start = 1'b0;
        b1.data  = 1'b0;
        b8.start = 1'b1;
        b8.data  = 8'hA5;
        rst_b = 1'b1;
        #1 rst_b = 1'b0;

        // Reset held with start asserted: everything stays quiet.
        repeat (3) begin
            @(negedge clk);
            chk("rst_outs", {b8.busy, b8.so, b8.so_vld, b8.sof, b8.eof, b8.crc}, 0);
        end
        @(negedge clk);
        push8(8'hA5, 4'hB);
        rst_b = 1'b1;
        @(negedge clk);
        chk("rst_release_sof", {b8.so_vld, b8.sof}, 2'b11);
        b8.start = 1'b0;
        wait_idle8();

        // Single-cycle start, busy length.
        @(negedge clk);
        b8.start = 1'b1;
        b8.data  = 8'hA5;
        push8(8'hA5, 4'hB);
        @(negedge clk);
        b8.start = 1'b0;
        n = 0;
        while (b8.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, 12);

        send8(8'h00, 4'h0);
        send8(8'h01, 4'h3);

        // start during DATA and on eof is ignored; start in the next IDLE launches a frame.
        @(negedge clk);
        b8.start = 1'b1;
        b8.data  = 8'h3C;
        push8(8'h3C, rem_ld(8'h3C, 8));
        @(negedge clk);
        b8.start = 1'b0;
        repeat (3) @(negedge clk);
        b8.start = 1'b1;
        b8.data  = 8'hFF;
        @(negedge clk);
        b8.start = 1'b0;
        n = 0;
        while (!b8.eof && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("eof_timeout", b8.eof, 1);
        b8.start = 1'b1;
        b8.data  = 8'h77;
        @(negedge clk);
        chk("gap_idle", b8.busy, 0);
        b8.data = 8'h81;
        push8(8'h81, rem_ld(8'h81, 8));
        @(negedge clk);
        b8.start = 1'b0;
        wait_idle8();

        // Asynchronous reset in the middle of the CRC phase.
        @(negedge clk);
        b8.start = 1'b1;
        b8.data  = 8'hA5;
        push8(8'hA5, 4'hB);
        @(negedge clk);
        b8.start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #3 rst_b = 1'b0;
        #1;
        chk("midrst_outs", {b8.busy, b8.so, b8.so_vld, b8.sof, b8.eof, b8.crc}, 0);
        q8.delete();
        @(negedge clk);
        rst_b = 1'b1;
        send8(8'hA5, 4'hB);

        for (int i = 0; i < 200; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            send8(d, rem_ld(d, 8));
        end

        // Single-bit payload variant.
        send1(1'b1, 4'h3);
        send1(1'b0, 4'h0);
        send1(1'b1, 4'h3);

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
